// File: rtl/ssr_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ssr_pkg
//   Shared types and widths for the speech-recognition sequencer slice.
//   ssr_state_t : sequencer FSM states
//   ADC_W/RES_W : ADC sample width and classifier result width
//   is_busy()   : true for every state that represents capture in progress
// -----------------------------------------------------------------------------
package ssr_pkg;

  localparam int ADC_W = 12;
  localparam int RES_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ADC_WAIT,
    FE_WAIT,
    CLS_WAIT,
    DONE,
    ERROR
  } ssr_state_t;

  function automatic logic is_busy(input ssr_state_t s);
    return !(s inside {IDLE, DONE, ERROR});
  endfunction

endpackage

// File: rtl/ssr_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// ssr_seq_ctrl_if
//   Bundles every sequencer signal except clock and reset.
//   master : the sequencer (drives adc_req, smp_*, frame_last, cls_start,
//            result*, busy, error, overrun)
//   slave  : the surrounding chain (drives start, abort, adc_ack/adc_data,
//            fe_done, cls_done/cls_value)
// -----------------------------------------------------------------------------
interface ssr_seq_ctrl_if;

  logic                      start;
  logic                      abort;
  logic                      adc_req;
  logic                      adc_ack;
  logic [ssr_pkg::ADC_W-1:0] adc_data;
  logic                      smp_valid;
  logic [ssr_pkg::ADC_W-1:0] smp_data;
  logic                      frame_last;
  logic                      fe_done;
  logic                      cls_start;
  logic                      cls_done;
  logic [ssr_pkg::RES_W-1:0] cls_value;
  logic [ssr_pkg::RES_W-1:0] result;
  logic                      result_valid;
  logic                      busy;
  logic                      error;
  logic                      overrun;

  modport master (
    input  start, abort, adc_ack, adc_data, fe_done, cls_done, cls_value,
    output adc_req, smp_valid, smp_data, frame_last, cls_start,
           result, result_valid, busy, error, overrun
  );

  modport slave (
    output start, abort, adc_ack, adc_data, fe_done, cls_done, cls_value,
    input  adc_req, smp_valid, smp_data, frame_last, cls_start,
           result, result_valid, busy, error, overrun
  );

endinterface

// File: rtl/ssr_seq_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// ssr_tick_gen
//   Free-running divider: counts 0..DIV-1 while enabled and emits a one-cycle
//   tick on the last count, then wraps. A synchronous clear restarts from 0.
//   clk, rst : clock, asynchronous active-low reset
//   en_i     : count enable (count holds when low)
//   clr_i    : synchronous clear, wins over enable
//   tick_o   : high for the cycle in which the count sits at DIV-1
// -----------------------------------------------------------------------------
module ssr_tick_gen #(
  parameter int unsigned DIV = 6250
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    // NOTE: default assignment first so every path drives cnt_d (no latch).
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/ssr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// ssr_seq_ctrl
//   Utterance sequencer: paces ADC reads, forwards samples to the feature
//   extractor, waits for per-frame completion, triggers one classification and
//   latches its result. Guards every wait with a timeout and flags missed
//   sample ticks as overrun.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : ssr_seq_ctrl_if.master (start/abort, ADC, FE, classifier,
//              result and status signals)
// -----------------------------------------------------------------------------
module ssr_seq_ctrl
  import ssr_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV        = 6250,
  parameter int unsigned SAMPLES_PER_FRAME = 256,
  parameter int unsigned NUM_FRAMES        = 32,
  parameter int unsigned TIMEOUT_CYC       = 1000000
) (
  input  logic            clk,
  input  logic            rst,
  ssr_seq_ctrl_if.master  bus
);

  localparam int unsigned SCW = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
  localparam int unsigned FCW = (NUM_FRAMES > 1)        ? $clog2(NUM_FRAMES)        : 1;
  localparam int unsigned TCW = (TIMEOUT_CYC > 1)       ? $clog2(TIMEOUT_CYC)       : 1;

  localparam logic [SCW-1:0] SMP_LAST = SCW'(SAMPLES_PER_FRAME - 1);
  localparam logic [FCW-1:0] FRM_LAST = FCW'(NUM_FRAMES - 1);
  localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYC - 1);

  ssr_state_t        state_q, state_d;
  logic              start_q;
  logic [SCW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [FCW-1:0]    frame_cnt_q, frame_cnt_d;
  logic [TCW-1:0]    to_cnt_q, to_cnt_d;
  logic              adc_req_q, adc_req_d;
  logic              smp_valid_q, smp_valid_d;
  logic [ADC_W-1:0]  smp_data_q, smp_data_d;
  logic              frame_last_q, frame_last_d;
  logic              cls_start_q, cls_start_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              result_valid_q, result_valid_d;
  logic              error_q, error_d;
  logic              overrun_q, overrun_d;

  logic tick, accept, abort_hit, timed_out, last_smp, last_frame;

  assign accept     = bus.start && !start_q && (state_q inside {IDLE, DONE, ERROR});
  assign abort_hit  = bus.abort && is_busy(state_q);
  assign timed_out  = (state_q inside {ADC_WAIT, FE_WAIT, CLS_WAIT}) && (to_cnt_q == TO_LAST);
  assign last_smp   = (sample_cnt_q == SMP_LAST);
  assign last_frame = (frame_cnt_q == FRM_LAST);

  // The sample clock keeps running through the ADC and FE waits so that a slow
  // responder shows up as a tick landing outside WAIT_TICK (overrun).
  ssr_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q inside {WAIT_TICK, ADC_WAIT, FE_WAIT}),
    .clr_i  (accept || abort_hit),
    .tick_o (tick)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      start_q        <= 1'b0;
      sample_cnt_q   <= '0;
      frame_cnt_q    <= '0;
      to_cnt_q       <= '0;
      adc_req_q      <= 1'b0;
      smp_valid_q    <= 1'b0;
      smp_data_q     <= '0;
      frame_last_q   <= 1'b0;
      cls_start_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= bus.start;
      sample_cnt_q   <= sample_cnt_d;
      frame_cnt_q    <= frame_cnt_d;
      to_cnt_q       <= to_cnt_d;
      adc_req_q      <= adc_req_d;
      smp_valid_q    <= smp_valid_d;
      smp_data_q     <= smp_data_d;
      frame_last_q   <= frame_last_d;
      cls_start_q    <= cls_start_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      overrun_q      <= overrun_d;
    end
  end

  // Next-state logic. In every wait the awaited pulse is checked before the
  // timeout, so a pulse arriving on the timeout cycle still counts.
  always_comb begin
    state_d = state_q;
    if (abort_hit) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE, ERROR: if (accept) state_d = WAIT_TICK;
        WAIT_TICK:         if (tick)   state_d = ADC_WAIT;
        ADC_WAIT: begin
          if (bus.adc_ack)    state_d = last_smp ? FE_WAIT : WAIT_TICK;
          else if (timed_out) state_d = ERROR;
        end
        FE_WAIT: begin
          if (bus.fe_done)    state_d = last_frame ? CLS_WAIT : WAIT_TICK;
          else if (timed_out) state_d = ERROR;
        end
        CLS_WAIT: begin
          if (bus.cls_done)   state_d = DONE;
          else if (timed_out) state_d = ERROR;
        end
        default:              state_d = IDLE;
      endcase
    end
  end

  // Output, counter and flag logic.
  always_comb begin
    adc_req_d      = 1'b0;
    smp_valid_d    = 1'b0;
    frame_last_d   = 1'b0;
    cls_start_d    = 1'b0;
    smp_data_d     = smp_data_q;
    sample_cnt_d   = sample_cnt_q;
    frame_cnt_d    = frame_cnt_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    error_d        = error_q;
    overrun_d      = overrun_q;

    if (accept) begin
      result_valid_d = 1'b0;
      error_d        = 1'b0;
      overrun_d      = 1'b0;
      sample_cnt_d   = '0;
      frame_cnt_d    = '0;
    end else if (abort_hit) begin
      sample_cnt_d   = '0;
      frame_cnt_d    = '0;
    end else begin
      unique case (state_q)
        WAIT_TICK: adc_req_d = tick;
        ADC_WAIT: begin
          // A tick here means the slot was missed; no extra read is issued.
          if (tick) overrun_d = 1'b1;
          if (bus.adc_ack) begin
            smp_valid_d  = 1'b1;
            smp_data_d   = bus.adc_data;
            frame_last_d = last_smp;
            sample_cnt_d = last_smp ? '0 : sample_cnt_q + SCW'(1);
          end else if (timed_out) begin
            error_d = 1'b1;
          end
        end
        FE_WAIT: begin
          if (tick) overrun_d = 1'b1;
          if (bus.fe_done) begin
            frame_cnt_d = last_frame ? '0 : frame_cnt_q + FCW'(1);
            cls_start_d = last_frame;
          end else if (timed_out) begin
            error_d = 1'b1;
          end
        end
        CLS_WAIT: begin
          if (bus.cls_done) begin
            result_d       = bus.cls_value;
            result_valid_d = 1'b1;
          end else if (timed_out) begin
            error_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // Timeout counter restarts on every entry to a wait state and saturates.
    if ((state_d inside {ADC_WAIT, FE_WAIT, CLS_WAIT}) && (state_d == state_q)) begin
      to_cnt_d = (to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TCW'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  assign bus.adc_req      = adc_req_q;
  assign bus.smp_valid    = smp_valid_q;
  assign bus.smp_data     = smp_data_q;
  assign bus.frame_last   = frame_last_q;
  assign bus.cls_start    = cls_start_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.error        = error_q;
  assign bus.overrun      = overrun_q;
  assign bus.busy         = is_busy(state_q);

endmodule

// File: tb/tb_ssr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ssr_seq_ctrl
//   Drives ssr_seq_ctrl with reactive ADC / feature-extractor / classifier
//   models and checks captures against the sequencing rules: every ADC read
//   reaches the extractor in order, every SPF-th sample closes a frame, one
//   classification per utterance, timing of first read, timeout and overrun.
// -----------------------------------------------------------------------------
module tb_ssr_seq_ctrl;
  import ssr_pkg::*;

  localparam int SD  = 4;
  localparam int SPF = 3;
  localparam int NF  = 2;
  localparam int TO  = 20;
  localparam int NS  = SPF * NF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ssr_seq_ctrl_if bus ();

  ssr_seq_ctrl #(
    .SAMPLE_DIV        (SD),
    .SAMPLES_PER_FRAME (SPF),
    .NUM_FRAMES        (NF),
    .TIMEOUT_CYC       (TO)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Responder configuration (written only by the test sequence).
  bit               adc_en = 1'b1, fe_en = 1'b1, cls_en = 1'b1;
  bit               nominal_data = 1'b1;
  bit               force_fe = 1'b0, force_cls = 1'b0;
  int               adc_delay = 1, fe_delay = 2, cls_delay = 3;
  int               data_base = 0;
  logic [RES_W-1:0] cls_val = 2'b10;

  // Monitor state (written only by the negedge process).
  int               cyc = 0, req_cnt = 0, cls_cnt = 0, lat_bad = 0;
  int               last_ack_cyc = -10, err_rise_cyc = -1;
  bit               err_prev = 1'b0;
  int               req_cyc_q[$];
  logic [ADC_W-1:0] sent_q[$];
  logic [ADC_W-1:0] got_q[$];
  bit               fl_q[$];
  bit               adc_pend = 1'b0, fe_pend = 1'b0, cls_pend = 1'b0;
  int               adc_wait = 0, fe_wait = 0, cls_wait = 0;

  // Delay d means the response is sampled by the DUT d clock edges after the
  // edge that raised the request.
  always @(negedge clk) begin
    bit adc_fire, fe_fire, cls_fire;
    cyc++;
    if (bus.adc_req) begin
      req_cnt++;
      req_cyc_q.push_back(cyc);
    end
    if (bus.smp_valid) begin
      got_q.push_back(bus.smp_data);
      fl_q.push_back(bus.frame_last);
      if (cyc != last_ack_cyc + 1) lat_bad++;
    end
    if (bus.cls_start) cls_cnt++;
    if (bus.error && !err_prev) err_rise_cyc = cyc;
    err_prev = bus.error;

    adc_fire = 1'b0; fe_fire = 1'b0; cls_fire = 1'b0;
    if (adc_pend) begin
      if (adc_wait == 0) begin adc_pend = 1'b0; adc_fire = 1'b1; end
      else adc_wait--;
    end
    if (bus.adc_req && adc_en) begin
      if (adc_delay <= 1) adc_fire = 1'b1;
      else begin adc_pend = 1'b1; adc_wait = adc_delay - 2; end
    end
    if (fe_pend) begin
      if (fe_wait == 0) begin fe_pend = 1'b0; fe_fire = 1'b1; end
      else fe_wait--;
    end
    if (bus.smp_valid && bus.frame_last && fe_en) begin
      if (fe_delay <= 1) fe_fire = 1'b1;
      else begin fe_pend = 1'b1; fe_wait = fe_delay - 2; end
    end
    if (cls_pend) begin
      if (cls_wait == 0) begin cls_pend = 1'b0; cls_fire = 1'b1; end
      else cls_wait--;
    end
    if (bus.cls_start && cls_en) begin
      if (cls_delay <= 1) cls_fire = 1'b1;
      else begin cls_pend = 1'b1; cls_wait = cls_delay - 2; end
    end

    bus.adc_ack  = adc_fire;
    bus.fe_done  = fe_fire || force_fe;
    bus.cls_done = cls_fire || force_cls;
    if (adc_fire) begin
      bus.adc_data = nominal_data ? ADC_W'(32'h100 + sent_q.size() - data_base)
                                  : ADC_W'($urandom);
      sent_q.push_back(bus.adc_data);
      last_ack_cyc = cyc;
    end
    if (cls_fire) bus.cls_value = cls_val;
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_start(output int sc);
    bus.start = 1'b0;
    step;
    bus.start = 1'b1;
    sc = cyc;
    step;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin step; n++; end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL %s: busy=%b after %0d cycles, want 0", nm, bus.busy, budget);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) step;
    total++;
    if ({bus.adc_req, bus.smp_valid, bus.frame_last, bus.cls_start, bus.result_valid,
         bus.busy, bus.error, bus.overrun, bus.result, bus.smp_data} !== '0) begin
      bad++; $display("FAIL reset_outputs: some output nonzero during reset, want all 0");
    end
    rst_n = 1'b1;
    repeat (6) step;
    total++;
    if (bus.busy !== 1'b0 || req_cnt !== 0) begin
      bad++; $display("FAIL reset_idle: busy=%b reqs=%0d, want 0/0", bus.busy, req_cnt);
    end
  endtask

  task automatic test_stray;
    int rb = req_cnt, cb = cls_cnt;
    force_fe = 1'b1; force_cls = 1'b1;
    step;
    force_fe = 1'b0; force_cls = 1'b0;
    repeat (8) step;
    total++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      bad++; $display("FAIL stray_state: busy=%b rv=%b, want 0/0", bus.busy, bus.result_valid);
    end
    total++;
    if (req_cnt != rb || cls_cnt != cb) begin
      bad++; $display("FAIL stray_pulses: reqs=%0d cls=%0d, want 0/0", req_cnt - rb, cls_cnt - cb);
    end
  endtask

  task automatic test_nominal;
    int sc, rb, gb, cb, qb, lb;
    adc_delay = 1; fe_delay = 2; cls_delay = 3; cls_val = 2'b10; nominal_data = 1'b1;
    data_base = sent_q.size();
    rb = req_cnt; gb = got_q.size(); cb = cls_cnt; qb = req_cyc_q.size(); lb = lat_bad;
    do_start(sc);
    wait_idle("nom_done", 300);
    total++;
    if (req_cnt - rb != NS) begin
      bad++; $display("FAIL nom_reqs: got %0d want %0d", req_cnt - rb, NS);
    end
    total++;
    if (got_q.size() - gb != NS) begin
      bad++; $display("FAIL nom_samples: got %0d want %0d", got_q.size() - gb, NS);
    end else begin
      for (int i = 0; i < NS; i++) begin
        logic [ADC_W-1:0] ev = ADC_W'(32'h100 + i);
        bit efl = ((i % SPF) == SPF - 1);
        total++;
        if (got_q[gb+i] !== ev || fl_q[gb+i] !== efl) begin
          bad++; $display("FAIL nom_smp%0d: data=%h last=%b want %h/%b", i, got_q[gb+i], fl_q[gb+i], ev, efl);
        end
      end
    end
    total++;
    if (req_cyc_q.size() <= qb || req_cyc_q[qb] != sc + SD + 1) begin
      bad++; $display("FAIL nom_first_req: start at %0d, want req at %0d", sc, sc + SD + 1);
    end
    total++;
    if (lat_bad != lb) begin
      bad++; $display("FAIL nom_latency: %0d samples not 1 cycle after ack, want 0", lat_bad - lb);
    end
    total++;
    if (cls_cnt - cb != 1 || bus.result !== 2'b10 || bus.result_valid !== 1'b1) begin
      bad++; $display("FAIL nom_result: cls=%0d res=%b rv=%b want 1/10/1", cls_cnt - cb, bus.result, bus.result_valid);
    end
    total++;
    if (bus.overrun !== 1'b0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL nom_flags: ovr=%b err=%b want 0/0", bus.overrun, bus.error);
    end
  endtask

  task automatic test_adc_timeout;
    int sc, qb, n = 0;
    adc_en = 1'b0;
    qb = req_cyc_q.size();
    do_start(sc);
    while (!bus.error && n < 200) begin step; n++; end
    total++;
    if (bus.error !== 1'b1 || req_cyc_q.size() != qb + 1 || err_rise_cyc - req_cyc_q[qb] != TO) begin
      bad++; $display("FAIL to_timing: err=%b reqs=%0d delay=%0d want 1/1/%0d", bus.error,
                      req_cyc_q.size() - qb, err_rise_cyc - req_cyc_q[qb], TO);
    end
    total++;
    if (bus.busy !== 1'b0 || bus.result_valid !== 1'b0) begin
      bad++; $display("FAIL to_state: busy=%b rv=%b want 0/0", bus.busy, bus.result_valid);
    end
    adc_en = 1'b1;
  endtask

  task automatic test_overrun;
    int sc, rb, gb, sb;
    adc_delay = 6;
    rb = req_cnt; gb = got_q.size(); sb = sent_q.size();
    do_start(sc);
    total++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL ovr_accept: err=%b busy=%b want 0/1", bus.error, bus.busy);
    end
    wait_idle("ovr_done", 400);
    total++;
    if (bus.overrun !== 1'b1 || bus.result_valid !== 1'b1 || bus.error !== 1'b0) begin
      bad++; $display("FAIL ovr_flags: ovr=%b rv=%b err=%b want 1/1/0", bus.overrun, bus.result_valid, bus.error);
    end
    total++;
    if (req_cnt - rb != NS || got_q.size() - gb != NS || got_q[gb+NS-1] !== sent_q[sb+NS-1]) begin
      bad++; $display("FAIL ovr_reqs: reqs=%0d samples=%0d want %0d/%0d", req_cnt - rb, got_q.size() - gb, NS, NS);
    end
    adc_delay = 1;
  endtask

  task automatic test_restart;
    int sc, rb, n = 0;
    rb = req_cnt;
    do_start(sc);
    total++;
    if (bus.result_valid !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL rst_clear: rv=%b ovr=%b busy=%b want 0/0/1", bus.result_valid, bus.overrun, bus.busy);
    end
    while (req_cnt < rb + 2 && n < 200) begin step; n++; end
    bus.start = 1'b0; step;
    bus.start = 1'b1; step;
    bus.start = 1'b0;
    wait_idle("rst_done", 300);
    total++;
    if (req_cnt - rb != NS || bus.result_valid !== 1'b1) begin
      bad++; $display("FAIL rst_busy_edge: reqs=%0d rv=%b want %0d/1", req_cnt - rb, bus.result_valid, NS);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 5; it++) begin
      int sc, rb, gb, sb, cb;
      bit eovr;
      adc_delay = $urandom_range(1, 3);
      fe_delay  = $urandom_range(1, 3);
      cls_delay = $urandom_range(1, 6);
      cls_val   = RES_W'($urandom);
      nominal_data = 1'b0;
      // A frame's FE wait that runs into the next sample tick drops that slot.
      eovr = (adc_delay + fe_delay >= SD);
      rb = req_cnt; gb = got_q.size(); sb = sent_q.size(); cb = cls_cnt;
      do_start(sc);
      wait_idle("rnd_done", 400);
      total++;
      if (req_cnt - rb != NS || got_q.size() - gb != NS || cls_cnt - cb != 1) begin
        bad++; $display("FAIL rnd%0d_counts: reqs=%0d samples=%0d cls=%0d want %0d/%0d/1",
                        it, req_cnt - rb, got_q.size() - gb, cls_cnt - cb, NS, NS);
      end else begin
        for (int i = 0; i < NS; i++) begin
          bit efl = ((i % SPF) == SPF - 1);
          total++;
          if (got_q[gb+i] !== sent_q[sb+i] || fl_q[gb+i] !== efl) begin
            bad++; $display("FAIL rnd%0d_smp%0d: data=%h last=%b want %h/%b", it, i, got_q[gb+i], fl_q[gb+i], sent_q[sb+i], efl);
          end
        end
      end
      total++;
      if (bus.result !== cls_val || bus.result_valid !== 1'b1 || bus.overrun !== eovr) begin
        bad++; $display("FAIL rnd%0d_result: res=%b rv=%b ovr=%b want %b/1/%b (d=%0d f=%0d)",
                        it, bus.result, bus.result_valid, bus.overrun, cls_val, eovr, adc_delay, fe_delay);
      end
    end
    adc_delay = 1; fe_delay = 2; cls_delay = 3; nominal_data = 1'b1;
  endtask

  task automatic test_abort;
    int sc, rb, gb, cb, n = 0;
    fe_en = 1'b0;
    rb = req_cnt; gb = got_q.size(); cb = cls_cnt;
    do_start(sc);
    while (got_q.size() < gb + SPF && n < 200) begin step; n++; end
    bus.abort = 1'b1;
    step;
    bus.abort = 1'b0;
    total++;
    if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      bad++; $display("FAIL abort_state: busy=%b err=%b want 0/0", bus.busy, bus.error);
    end
    repeat (12) step;
    total++;
    if (req_cnt - rb != SPF || cls_cnt != cb || bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL abort_after: reqs=%0d cls=%0d rv=%b busy=%b want %0d/0/0/0",
                      req_cnt - rb, cls_cnt - cb, bus.result_valid, bus.busy, SPF);
    end
    fe_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int sc, rb, n = 0;
    adc_en = 1'b0;
    rb = req_cnt;
    do_start(sc);
    while (!bus.adc_req && n < 200) begin step; n++; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.adc_req, bus.smp_valid, bus.frame_last, bus.cls_start, bus.result_valid,
         bus.busy, bus.error, bus.overrun, bus.result, bus.smp_data} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: req=%b busy=%b res=%b data=%h want all 0",
                      bus.adc_req, bus.busy, bus.result, bus.smp_data);
    end
    bus.start = 1'b0;
    repeat (2) step;
    rst_n = 1'b1;
    rb = req_cnt;
    repeat (12) step;
    total++;
    if (req_cnt != rb || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rstmid_idle: reqs=%0d busy=%b want 0/0", req_cnt - rb, bus.busy);
    end
    adc_en = 1'b1;
  endtask

  initial begin
    test_reset;
    test_stray;
    test_nominal;
    test_adc_timeout;
    test_overrun;
    test_restart;
    test_random;
    test_abort;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ssr_seq_ctrl.md
Name: ssr_seq_ctrl

Overview:
Central sequencer for the speech-recognition chain: ADC front end, feature extractor, classifier and LED logic. It turns a start request into a paced utterance capture: timed ADC read requests, sample forwarding to the feature extractor, and per-frame completion checks. It then triggers one classification and latches the result for the LED logic. It also owns timeouts and sample-overrun detection, so a stalled I2C ADC or a stalled downstream block cannot hang the system.

Parameters:
SAMPLE_DIV, 6250, clk cycles per sample period (100 MHz / 16 kHz)
SAMPLES_PER_FRAME, 256, samples forwarded per frame
NUM_FRAMES, 32, frames per utterance
TIMEOUT_CYC, 1000000, max cycles waiting on any single ack/done
ADC_W, 12, ADC sample width
RES_W, 2, classifier result width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  start request, level (already synchronised); rising edge is the trigger
abort  in  1  synchronous abort, level
adc_req  out  1  one-cycle pulse: perform one ADC read
adc_ack  in  1  one-cycle pulse: adc_data valid
adc_data  in  ADC_W  sample from ADC interface
smp_valid  out  1  one-cycle pulse: smp_data to feature extractor
smp_data  out  ADC_W  registered copy of adc_data
frame_last  out  1  asserted together with smp_valid on the last sample of a frame
fe_done  in  1  pulse: feature extractor finished current frame
cls_start  out  1  one-cycle pulse: run classifier on accumulated features
cls_done  in  1  pulse: cls_value valid
cls_value  in  RES_W  classifier output
result  out  RES_W  latched classification
result_valid  out  1  high from latch until next start
busy  out  1  high in any state except IDLE/DONE/ERROR
error  out  1  sticky: timeout occurred; cleared on next accepted start
overrun  out  1  sticky: a sample tick was missed; cleared on next accepted start

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; start edge register 0.
- Start acceptance:
  - Trigger is the rising edge of start (registered previous value), accepted only in IDLE, DONE or ERROR.
  - On acceptance: clear result_valid, error and overrun; zero the counters; go to WAIT_TICK.
- Edges outside those states are ignored.
- Pacing divider:
  - Counts 0..SAMPLE_DIV-1 only while in WAIT_TICK, ADC_WAIT or FE_WAIT.
  - tick = count reaches SAMPLE_DIV-1, after which the count wraps to 0.
  - The divider restarts from 0 on start acceptance. The first tick occurs SAMPLE_DIV cycles after acceptance.
- States:
  - IDLE: waits for start.
  - WAIT_TICK: on tick, pulse adc_req, clear the timeout counter, go to ADC_WAIT.
  - ADC_WAIT:
    - On adc_ack: register adc_data into smp_data and pulse smp_valid the next cycle (latency 1 from ack).
    - frame_last = (sample_cnt == SAMPLES_PER_FRAME-1).
    - Non-last sample: sample_cnt++, go to WAIT_TICK.
    - Last sample: sample_cnt wraps to 0, go to FE_WAIT.
  - FE_WAIT:
    - On fe_done, frame_cnt++.
    - If frame_cnt was NUM_FRAMES-1: pulse cls_start, go to CLS_WAIT.
    - Otherwise go to WAIT_TICK.
  - CLS_WAIT: on cls_done, result <= cls_value, result_valid <= 1, go to DONE.
  - DONE: holds result; a new start edge restarts capture.
  - ERROR: result_valid 0; a new start edge restarts capture.
- Overrun: a tick while in ADC_WAIT or FE_WAIT sets overrun. No extra adc_req is issued; that sample slot is dropped and capture continues.
- Timeout:
  - The timeout counter clears on entry to ADC_WAIT, FE_WAIT and CLS_WAIT.
  - It increments each cycle in those states, saturating.
  - Reaching TIMEOUT_CYC-1 without the awaited pulse sets error and goes to ERROR; busy drops.
- Stray pulses: adc_ack, fe_done or cls_done outside their waiting state are ignored.
- Same-cycle tie: if the awaited pulse and the timeout occur in the same cycle, the pulse wins.
- Abort: abort=1 in any busy state goes to IDLE next cycle. Counters zero, no result latched, error unchanged.
- Async reset mid-operation: immediate return to reset values. Output pulses are truncated.

Decomposition:
- Package ssr_pkg holds:
  - state enum ssr_state_t (IDLE, WAIT_TICK, ADC_WAIT, FE_WAIT, CLS_WAIT, DONE, ERROR)
  - RES_W and ADC_W localparams
- Sub-module ssr_tick_gen: parameterised divider with enable and sync clear, output one-cycle tick. Reused later for LED blink timing.

Test Plan:
Bench parameters unless noted: SAMPLE_DIV=4, SAMPLES_PER_FRAME=3, NUM_FRAMES=2, TIMEOUT_CYC=20.
- Nominal:
  - Stimulus: start edge; ADC model acks 1 cycle after each adc_req with data 0x100+n; fe_done 2 cycles after frame_last; cls_done 3 cycles after cls_start with value 2'b10.
  - Response: exactly 6 adc_req; smp_data sequence 0x100..0x105; frame_last on the 3rd and 6th samples; one cls_start; result=2'b10 and result_valid=1; busy=0.
- ADC timeout: adc_ack never returns -> error=1 exactly 20 cycles after adc_req; state ERROR; result_valid=0; busy=0.
- Overrun: ADC acks 6 cycles after adc_req -> overrun=1; the dropped tick issues no adc_req; capture still completes with result_valid=1.
- Restart and clearing: new start edge in DONE clears result_valid and overrun the same cycle after acceptance. A start edge while busy is ignored (adc_req count unchanged).
- Abort and reset: abort during FE_WAIT -> IDLE next cycle with no cls_start. rst low during ADC_WAIT -> all outputs 0 immediately; after release, state IDLE with no spontaneous adc_req.
- Stray pulses: fe_done and cls_done asserted in IDLE -> no state change; result_valid stays 0.
